// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
//
// Registered 4-bit to 7-segment decoder for one common-anode HEX digit.
// The decode is purely combinational; the only state is the output register.
//
// Parameters:
//   HEX_MODE   - 1: codes 10..15 show A b C d E F. 0: codes 10..15 blank.
//   ACTIVE_LOW - 1: a lit segment drives 0. 0: a lit segment drives 1.
//
// Ports:
//   clk     in   1  rising-edge clock
//   reset_n in   1  synchronous reset, active-low (loads all-off pattern)
//   bcd     in   4  digit code 0..15
//   leds    out  7  segment drive, leds[0]=a .. leds[6]=g, registered
// -----------------------------------------------------------------------------
module seg7_decoder #(
    parameter bit HEX_MODE   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] bcd,
    output logic [6:0] leds
);

    localparam logic [6:0] ALL_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    // Pattern is built in active-low form, then flipped for active-high panels.
    logic [6:0] pat_n;
    logic [6:0] pat;

    always_comb begin
        pat_n = 7'h7F;
        case (bcd)
            4'h0: pat_n = 7'h40;
            4'h1: pat_n = 7'h79;
            4'h2: pat_n = 7'h24;
            4'h3: pat_n = 7'h30;
            4'h4: pat_n = 7'h19;
            4'h5: pat_n = 7'h12;
            4'h6: pat_n = 7'h02;
            4'h7: pat_n = 7'h78;
            4'h8: pat_n = 7'h00;
            4'h9: pat_n = 7'h10;
            4'hA: pat_n = HEX_MODE ? 7'h08 : 7'h7F;
            4'hB: pat_n = HEX_MODE ? 7'h03 : 7'h7F;
            4'hC: pat_n = HEX_MODE ? 7'h46 : 7'h7F;
            4'hD: pat_n = HEX_MODE ? 7'h21 : 7'h7F;
            4'hE: pat_n = HEX_MODE ? 7'h06 : 7'h7F;
            4'hF: pat_n = HEX_MODE ? 7'h0E : 7'h7F;
            default: pat_n = 7'h7F;
        endcase
    end

    assign pat = ACTIVE_LOW ? pat_n : ~pat_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            leds <= ALL_OFF;
        end else begin
            leds <= pat;
        end
    end

endmodule

// File: tb/tb_seg7_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_decoder
//
// Drives five decoder instances from one clock: default, HEX_MODE=0,
// ACTIVE_LOW=0, and a two-digit pair fed from an 8-bit value. Expected
// patterns are computed from a reference table when inputs are driven,
// queued, and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_seg7_decoder;

    logic       clk;
    logic       reset_n;
    logic [3:0] bcd;
    logic [7:0] vals;
    logic [6:0] leds_main;
    logic [6:0] leds_hex0;
    logic [6:0] leds_al0;
    logic [6:0] leds_d0;
    logic [6:0] leds_d1;
    logic [3:0] nib_lo;
    logic [3:0] nib_hi;

    int n_cmp = 0;
    int n_err = 0;

    assign nib_lo = vals[3:0];
    assign nib_hi = vals[7:4];

    seg7_decoder u_main (.clk(clk), .reset_n(reset_n), .bcd(bcd), .leds(leds_main));

    seg7_decoder #(.HEX_MODE(1'b0)) u_hex0 (
        .clk(clk), .reset_n(reset_n), .bcd(bcd), .leds(leds_hex0));

    seg7_decoder #(.ACTIVE_LOW(1'b0)) u_al0 (
        .clk(clk), .reset_n(reset_n), .bcd(bcd), .leds(leds_al0));

    seg7_decoder u_d0 (.clk(clk), .reset_n(reset_n), .bcd(nib_lo), .leds(leds_d0));
    seg7_decoder u_d1 (.clk(clk), .reset_n(reset_n), .bcd(nib_hi), .leds(leds_d1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference patterns, active-low, HEX_MODE=1.
    localparam logic [6:0] TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        string      tag;
        logic [6:0] e_main;
        logic [6:0] e_hex0;
        logic [6:0] e_al0;
        logic [6:0] e_d0;
        logic [6:0] e_d1;
    } exp_t;

    exp_t sb[$];

    function automatic logic [6:0] model(input logic rst, input logic [3:0] c,
                                         input bit hex, input bit al);
        logic [6:0] p;
        if (!rst) begin
            p = 7'h7F;
        end else begin
            p = TBL[c];
            if (!hex && c >= 4'd10) p = 7'h7F;
        end
        return al ? p : ~p;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue expectations, clock it, then score.
    task automatic step(input logic rst, input logic [3:0] b, input logic [7:0] v,
                        input string tag);
        exp_t e;
        exp_t got;
        reset_n = rst;
        bcd     = b;
        vals    = v;
        e.tag    = tag;
        e.e_main = model(rst, b, 1'b1, 1'b1);
        e.e_hex0 = model(rst, b, 1'b0, 1'b1);
        e.e_al0  = model(rst, b, 1'b1, 1'b0);
        e.e_d0   = model(rst, v[3:0], 1'b1, 1'b1);
        e.e_d1   = model(rst, v[7:4], 1'b1, 1'b1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_cmp++;
        assert (sb.size() == 1)
        else begin
            n_err++;
            $error("FAIL %s_sbsize observed=%0d expected=1", tag, sb.size());
        end
        got = sb.pop_front();
        chk({got.tag, "_main"}, leds_main, got.e_main);
        chk({got.tag, "_hex0"}, leds_hex0, got.e_hex0);
        chk({got.tag, "_al0"},  leds_al0,  got.e_al0);
        chk({got.tag, "_d0"},   leds_d0,   got.e_d0);
        chk({got.tag, "_d1"},   leds_d1,   got.e_d1);
    endtask

    initial begin
        reset_n = 1'b0;
        bcd     = 4'd8;
        vals    = 8'h88;

        // Reset held for two edges with bcd=8.
        step(1'b0, 4'd8, 8'h88, "rst0");
        chk("rst0_const", leds_main, 7'h7F);
        chk("rst0_al0_const", leds_al0, 7'h00);
        step(1'b0, 4'd8, 8'h88, "rst1");
        chk("rst1_const", leds_main, 7'h7F);
        step(1'b1, 4'd8, 8'h88, "release");
        chk("release_const", leds_main, 7'h00);

        // Reset dropped between edges must not disturb the registered output.
        reset_n = 1'b0;
        #3;
        chk("between_edges_main", leds_main, 7'h00);
        chk("between_edges_al0", leds_al0, 7'h7F);

        // Full code sweep, one code per cycle.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i[3:0], {i[3:0], i[3:0]}, $sformatf("sweep%0d", i));
        end

        // Spot checks against literal values.
        step(1'b1, 4'd0, 8'h00, "al0_zero");
        chk("al0_zero_const", leds_al0, 7'h3F);
        step(1'b1, 4'd1, 8'h11, "al0_one");
        chk("al0_one_const", leds_al0, 7'h06);
        step(1'b1, 4'd9, 8'h99, "hex0_nine");
        chk("hex0_nine_const", leds_hex0, 7'h10);
        step(1'b1, 4'hC, 8'hCC, "hex0_c");
        chk("hex0_c_const", leds_hex0, 7'h7F);
        chk("main_c_const", leds_main, 7'h46);
        step(1'b0, 4'd1, 8'h11, "al0_rst");
        chk("al0_rst_const", leds_al0, 7'h00);

        // Single-cycle reset mid-stream.
        step(1'b1, 4'd3, 8'h33, "mid_a");
        chk("mid_a_const", leds_main, 7'h30);
        step(1'b0, 4'd7, 8'h77, "mid_b");
        chk("mid_b_const", leds_main, 7'h7F);
        step(1'b1, 4'd3, 8'h33, "mid_c");
        chk("mid_c_const", leds_main, 7'h30);

        // Two-digit sweep over every 8-bit value.
        for (int v = 0; v < 256; v++) begin
            step(1'b1, v[3:0], v[7:0], $sformatf("dual%02h", v));
        end

        step(1'b1, 4'hA, 8'h5A, "dual_5a");
        chk("disp0_5a_const", leds_d0, 7'h08);
        chk("disp1_5a_const", leds_d1, 7'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
